// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX system-bus controller: register offsets,
// FSM state type, divisor floor and stop-bit encodings.
package uart_tx_pkg;

  localparam logic [23:0] OFF_DATA    = 24'h00;
  localparam logic [23:0] OFF_BUSY    = 24'h04;
  localparam logic [23:0] OFF_DIV     = 24'h08;
  localparam logic [23:0] OFF_PARITY  = 24'h0C;
  localparam logic [23:0] OFF_STOPBIT = 24'h10;
  localparam logic [23:0] OFF_COUNT   = 24'h14;
  localparam logic [23:0] OFF_OVF     = 24'h18;
  localparam logic [23:0] OFF_SRST    = 24'h24;

  localparam logic [15:0] MIN_DIV     = 16'd16;
  localparam logic [1:0]  STOPBIT_ONE = 2'd1;
  localparam logic [1:0]  STOPBIT_TWO = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO for the UART transmitter; power-of-two depth,
// combinational head read, synchronous clear.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the push needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// UART TX system-bus controller: register file, read mux and bit-serial FSM.
// Optional interrupt logic is built only when UART_TX_IRQ_EN is defined.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a byte in the FIFO
// ST_START  | start bit (0) for div cycles
// ST_DATA   | 8 data bits LSB-first, div cycles each
// ST_PARITY | even parity bit for div cycles
// ST_STOP   | stop bit(s) (1), div cycles each
module uart_tx_sb_ctrl
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 1042
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o,
  output logic        irq_req_o,
  input  logic        irq_ret_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_d;
  logic        pop;
  logic        baud_end;

  logic [15:0] div_q;
  logic        parity_en_q;
  logic [1:0]  stopbit_q;
  logic        ovf_q;

  logic [23:0] off;
  logic        wr_acc, rd_acc, push_req, soft_rst, busy, cfg_wr_ok;
  logic [7:0]  fifo_rdata;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0] rdata_d;
  logic        unused_bits;

  assign off       = addr_i[23:0];
  assign wr_acc    = req_i & write_enable_i;
  assign rd_acc    = req_i & ~write_enable_i;
  assign push_req  = wr_acc && (off == OFF_DATA);
  assign soft_rst  = wr_acc && (off == OFF_SRST) && write_data_i[0];
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign cfg_wr_ok = wr_acc && !busy;
  assign baud_end  = (baud_q == div_q - 16'd1);
  assign unused_bits = ^{addr_i[31:24], write_data_i[31:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (soft_rst),
    .push_i   (push_req),
    .wdata_i  (write_data_i[7:0]),
    .pop_i    (pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          shift_d = fifo_rdata;
          par_d   = ^fifo_rdata;
        end
      end
      ST_START: if (baud_end) state_d = ST_DATA;
      ST_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = parity_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (baud_end) state_d = ST_STOP;
      ST_STOP: begin
        if (baud_end) begin
          if (stopbit_q == STOPBIT_TWO && !stop_q) begin
            stop_d = 1'b1;
          end else if (!fifo_empty) begin
            // back-to-back frame: straight into the next start bit
            pop     = 1'b1;
            state_d = ST_START;
            shift_d = fifo_rdata;
            par_d   = ^fifo_rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      baud_d = '0;
      bit_d  = '0;
      stop_d = 1'b0;
    end else if (baud_end) begin
      baud_d = '0;
    end

    if (soft_rst) begin
      state_d = ST_IDLE;
      baud_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
      pop     = 1'b0;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_o    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_o    <= tx_d;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      div_q       <= 16'(DEFAULT_DIV);
      parity_en_q <= 1'b0;
      stopbit_q   <= STOPBIT_ONE;
      ovf_q       <= 1'b0;
    end else begin
      if (cfg_wr_ok && off == OFF_DIV && write_data_i[15:0] >= MIN_DIV)
        div_q <= write_data_i[15:0];
      if (cfg_wr_ok && off == OFF_PARITY)
        parity_en_q <= write_data_i[0];
      if (cfg_wr_ok && off == OFF_STOPBIT)
        stopbit_q <= write_data_i[1:0];
      if (soft_rst)
        ovf_q <= 1'b0;
      else if (push_req && fifo_full && !pop)
        ovf_q <= 1'b1;
      else if (wr_acc && off == OFF_OVF && write_data_i[0])
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (off)
      OFF_BUSY:    rdata_d = {31'd0, busy};
      OFF_DIV:     rdata_d = {16'd0, div_q};
      OFF_PARITY:  rdata_d = {31'd0, parity_en_q};
      OFF_STOPBIT: rdata_d = {30'd0, stopbit_q};
      OFF_COUNT:   rdata_d = {{(32-CW){1'b0}}, fifo_count};
      OFF_OVF:     rdata_d = {31'd0, ovf_q};
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)   read_data_o <= '0;
    else if (rd_acc) read_data_o <= rdata_d;
  end

`ifdef UART_TX_IRQ_EN
  logic busy_q, irq_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      busy_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      // a soft-reset abort must not look like a completed transfer
      busy_q <= busy & ~soft_rst;
      if (soft_rst)             irq_q <= 1'b0;
      else if (busy_q && !busy) irq_q <= 1'b1;
      else if (irq_ret_i)       irq_q <= 1'b0;
    end
  end

  assign irq_req_o = irq_q;
`else
  logic unused_irq_ret;
  assign unused_irq_ret = irq_ret_i;
  assign irq_req_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Directed bench for uart_tx_sb_ctrl; register reads are scored through an
// expected-value queue drained by a monitor, line timing is checked inline.
`timescale 1ns/1ps
module tb_uart_tx_sb_ctrl;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        req_i;
  logic        write_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        tx_o;
  logic        irq_req_o;
  logic        irq_ret_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  logic rd_v   = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;
  logic [7:0]  byte_v;

  uart_tx_sb_ctrl #(.FIFO_DEPTH(8), .DEFAULT_DIV(1042)) dut (
    .clk_i          (clk_i),
    .resetn_i       (resetn_i),
    .req_i          (req_i),
    .write_enable_i (write_enable_i),
    .addr_i         (addr_i),
    .write_data_i   (write_data_i),
    .read_data_o    (read_data_o),
    .tx_o           (tx_o),
    .irq_req_o      (irq_req_o),
    .irq_ret_i      (irq_ret_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) rd_v <= req_i && !write_enable_i && resetn_i;

  always @(negedge clk_i) begin
    if (rd_v) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: read_data_o=%0h with nothing expected", read_data_o);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (read_data_o !== mon_exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", mon_name, read_data_o, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
    @(negedge clk_i);
    req_i = 1'b0; write_enable_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, e);
    end
  endtask

  task automatic wait_to(input int d);
    while (cyc < base + d) @(negedge clk_i);
  endtask

  initial begin
    resetn_i = 1'b0; req_i = 1'b0; write_enable_i = 1'b0;
    addr_i = '0; write_data_i = '0; irq_ret_i = 1'b0;
    tick(3);
    check("rst_tx", tx_o, 1);
    check("rst_irq", irq_req_o, 0);
    check("rst_rdata", read_data_o, 0);
    resetn_i = 1'b1;
    tick(1);

    rd(32'h04, 0, "rst_busy");
    rd(32'h08, 1042, "rst_div");
    rd(32'h10, 1, "rst_stopbit");
    rd(32'h0C, 0, "rst_parity");
    rd(32'h14, 0, "rst_count");
    rd(32'h18, 0, "rst_ovf");

    wr(32'h08, 15);
    rd(32'h08, 1042, "div_below_min_ignored");
    wr(32'h08, 16);
    rd(32'h08, 16, "div_write");
    rd(32'hFF000008, 16, "div_upper_addr_ignored");
    wr(32'h04, 32'h5);
    rd(32'h04, 0, "ro_write_ignored");
    rd(32'h20, 0, "unmapped_read");
    rd(32'h00, 0, "wo_data_read");
    rd(32'h24, 0, "wo_srst_read");

    // frame 1: 0xA5, no parity, one stop bit
    byte_v = 8'hA5;
    wr(32'h00, 32'hA5); base = cyc;
    check("f1_tx_before_start", tx_o, 1);
    wait_to(1);  check("f1_start_fall", tx_o, 0);
    wait_to(16); check("f1_start_last", tx_o, 0);
    wait_to(17); check("f1_bit0_edge", tx_o, 1);
    for (int i = 0; i < 8; i++) begin
      wait_to(25 + 16*i);
      check($sformatf("f1_bit%0d", i), tx_o, byte_v[i]);
    end
    wait_to(153); check("f1_stop", tx_o, 1);
    wait_to(160);
    rd(32'h04, 1, "f1_busy_last_stop");
    check("f1_irq_low_while_busy", irq_req_o, 0);
    rd(32'h04, 0, "f1_busy_fall");
`ifdef UART_TX_IRQ_EN
    check("irq_set", irq_req_o, 1);
    irq_ret_i = 1'b1; tick(1); irq_ret_i = 1'b0;
    check("irq_cleared", irq_req_o, 0);
`else
    check("irq_tied_low", irq_req_o, 0);
`endif

    // frame 2: 0x07 with even parity and two stop bits
    wr(32'h0C, 1);
    wr(32'h10, 2);
    rd(32'h0C, 1, "parity_rb");
    rd(32'h10, 2, "stopbit_rb");
    byte_v = 8'h07;
    wr(32'h00, 32'h07); base = cyc;
    wait_to(1); check("f2_start_fall", tx_o, 0);
    for (int i = 0; i < 8; i++) begin
      wait_to(25 + 16*i);
      check($sformatf("f2_bit%0d", i), tx_o, byte_v[i]);
    end
    wait_to(153); check("f2_parity", tx_o, 1);
    wait_to(169); check("f2_stop1", tx_o, 1);
    wait_to(185); check("f2_stop2", tx_o, 1);
    wait_to(192);
    rd(32'h04, 1, "f2_busy_last_stop");
    rd(32'h04, 0, "f2_busy_fall");
    irq_ret_i = 1'b1; tick(1); irq_ret_i = 1'b0;

    // ten back-to-back pushes into an 8-deep FIFO
    wr(32'h0C, 0);
    wr(32'h10, 1);
    wr(32'h00, 32'h30); base = cyc;
    for (int i = 1; i < 10; i++) wr(32'h00, 32'h30 + i);
    rd(32'h14, 8, "ovf_count_full");
    rd(32'h18, 1, "ovf_flag_set");
    wr(32'h18, 1);
    rd(32'h18, 0, "ovf_flag_rw1c");
    rd(32'h04, 1, "ovf_busy");
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        wait_to(160*k);
        check($sformatf("b2b_stop_before_f%0d", k), tx_o, 1);
      end
      wait_to(160*k + 1);
      check($sformatf("b2b_start_f%0d", k), tx_o, 0);
      wait_to(160*k + 25);
      check($sformatf("b2b_bit0_f%0d", k), tx_o, k % 2);
    end
    wait_to(1440);
    rd(32'h04, 1, "b2b_busy_last_stop");
    rd(32'h04, 0, "b2b_busy_fall");
    rd(32'h14, 0, "b2b_count_drained");

    // soft reset in the middle of a data bit
    wr(32'h00, 32'h00); base = cyc;
    wr(32'h00, 32'h55);
    wr(32'h08, 32);
    wait_to(40); check("srst_pre_data", tx_o, 0);
    wr(32'h24, 1);
    check("srst_tx_high", tx_o, 1);
    rd(32'h14, 0, "srst_count");
    rd(32'h08, 16, "srst_div_kept");
    rd(32'h04, 0, "srst_busy");
    rd(32'h0C, 0, "srst_parity_kept");
    tick(20);
    check("srst_tx_stays_high", tx_o, 1);
    check("srst_irq", irq_req_o, 0);

    // asynchronous reset in mid-frame
    wr(32'h00, 32'h00); base = cyc;
    wait_to(30); check("arst_pre_data", tx_o, 0);
    #2 resetn_i = 1'b0;
    #1 check("arst_tx_immediate", tx_o, 1);
    check("arst_rdata", read_data_o, 0);
    @(negedge clk_i);
    resetn_i = 1'b1;
    tick(1);
    rd(32'h08, 1042, "arst_div_default");
    rd(32'h04, 0, "arst_busy");
    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
